regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file's single write port. It round-robin arbitrates up to NREQ writeback sources (ALU, load unit, multicycle mul/div) onto the write port through a registered stage. It also keeps a per-register pending scoreboard, which issue logic sets and queries to detect RAW/WAW hazards on the two read ports.

## Interface
- NREQ, default 3: number of writeback requesters, 2..8.
- XLEN, default 32: data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a writeback pending.
- req_ready  out  NREQ  one-hot grant; the transfer occurs when valid & ready.
- req_rd  in  NREQ*5  destination register, slice i = [5i+4:5i].
- req_data  in  NREQ*XLEN  writeback data, slice i.
- we  out  1  register-file write enable (registered).
- rw  out  5  register-file write address (registered).
- busw  out  XLEN  register-file write data (registered).
- issue_valid  in  1  issue logic wants to mark issue_rd pending.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_stall  out  1  issue not accepted this cycle (WAW).
- ra, rb  in  5  read addresses presented to the register file.
- hz_a, hz_b  out  1  pending[ra] / pending[rb] (combinational).
- pending  out  32  scoreboard, for debug.

## Operation
- Arbiter: 3-bit round-robin pointer ptr. The grant goes to the first i with req_valid[i], searching from ptr upward with wrap. req_ready is combinational and is never asserted without the matching valid. No grant if no valid.
- On a grant to index g: ptr <= (g+1) mod NREQ. If no grant, ptr holds.
- Output stage: on a grant, we <= (req_rd[g] != 0), rw <= req_rd[g], busw <= req_data[g]. With no grant, we <= 0 and rw/busw hold.
- rd = 0 requests are accepted (ready asserted) and dropped (we=0).
- Scoreboard, per register r, r != 0:
  - Clear when we && rw==r.
  - Set when issue accepted with issue_rd==r.
  - Set wins over clear.
  - pending[0] is constant 0.
- issue_stall = issue_valid && issue_rd!=0 && pending[issue_rd] && !(we && rw==issue_rd).
  - Issue is accepted when issue_valid && !issue_stall.
  - issue_rd = 0 is accepted with no effect.
- A writeback to a non-pending register is legal. The write is performed and the clear is a no-op.
- hz_a/hz_b reflect the current pending value. They drop on the same edge at which the register file captures the write, so a read with hz=0 always sees final data.

## Timing
- Reset values (async, on rst_n low): ptr=0, we=0, rw=0, busw=0, pending=0. req_ready follows req_valid with ptr=0; issue_stall=0.
- Latency: grant in cycle N, we/rw/busw valid in cycle N+1, register file updated at the end of N+1, pending clear at the same edge.
- Throughput: one writeback per cycle. Each requester waits at most NREQ-1 grants.
- Requesters must hold req_rd/req_data stable while valid && !ready.
- Reset mid-operation: a grant accepted in the cycle before rst_n falls is lost (we forced 0). Requesters and issue logic are reset together.
- Simultaneous issue and writeback to the same register in one cycle: the issue is accepted and the bit stays set (new owner).

## Structure
- Package regfile_pkg holds:
  - REG_AW=5, NREG=32, XLEN=32.
  - Typedef reg_idx_t (logic [4:0]).
  - Typedef wb_req_t {reg_idx_t rd; logic [XLEN-1:0] data}.
- Sub-module rr_arbiter (parameter N): req, ptr in; one-hot gnt and encoded gnt_idx out. Purely combinational; the pointer register lives in regfile_wb_sched.

## Test plan
- Single request, NREQ=3: req_valid=3'b010, rd=5, data=32'hDEAD_BEEF → ready=3'b010 in cycle 0. Cycle 1: we=1, rw=5, busw=32'hDEADBEEF. ptr=2.
- All three valid continuously from reset, distinct rd 1/2/3 → grants 0,1,2,0,… in order. we=1 every cycle from cycle 1.
- Issue rd=7, then ra=7 → hz_a=1. After writeback rd=7, hz_a=0 in the cycle after we=1. A second issue rd=7 while pending gives issue_stall=1.
- Same-cycle clear and issue on rd=9 (we=1, rw=9, issue_valid=1, issue_rd=9) → issue_stall=0, and pending[9] stays 1 next cycle.
- rd=0 cases: writeback with rd=0, data=32'h1234 → ready=1, we=0 next cycle. Issue rd=0 → no stall, pending unchanged (bit 0 always 0).
- rst_n asserted low mid-stream with pending=32'h0000_0F00 and we=1 → immediately pending=0, we=0, rw=0, busw=0, ptr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file widths and writeback request types.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int XLEN   = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant search starting at ptr_i.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [2:0]   gnt_idx_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [3:0] idx;
    logic       found;

    // ptr_i is always below N, so one wrap subtraction is sufficient.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_i} + 4'(k);
            if (idx >= 4'(N)) begin
                idx = idx - 4'(N);
            end
            if (!found && req_i[idx[IW-1:0]]) begin
                found                = 1'b1;
                gnt_o[idx[IW-1:0]]   = 1'b1;
                gnt_idx_o            = idx[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched
// Description : Round-robin writeback scheduler and pending-register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*5-1:0]    req_rd_i,
    input  logic [NREQ*XLEN-1:0] req_data_i,
    output logic                 we_o,
    output logic [4:0]           rw_o,
    output logic [XLEN-1:0]      busw_o,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    output logic                 issue_stall_o,
    input  logic [4:0]           ra_i,
    input  logic [4:0]           rb_i,
    output logic                 hz_a_o,
    output logic                 hz_b_o,
    output logic [31:0]          pending_o
);

    import regfile_pkg::*;

    logic [2:0]      ptr_q, ptr_d;
    logic            we_q, we_d;
    reg_idx_t        rw_q, rw_d;
    logic [XLEN-1:0] busw_q, busw_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_idx;
    logic            gnt_any;
    reg_idx_t        gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic            issue_acc;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign gnt_any  = |gnt;
    assign gnt_rd   = req_rd_i[REG_AW*int'(gnt_idx) +: REG_AW];
    assign gnt_data = req_data_i[XLEN*int'(gnt_idx) +: XLEN];

    // A write landing on issue_rd this cycle frees it, so the new owner may issue.
    assign issue_stall_o = issue_valid_i && (issue_rd_i != '0) && pending_q[issue_rd_i]
                           && !(we_q && (rw_q == issue_rd_i));
    assign issue_acc     = issue_valid_i && !issue_stall_o;

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        rw_d   = rw_q;
        busw_d = busw_q;
        if (gnt_any) begin
            ptr_d  = (int'(gnt_idx) == NREQ-1) ? 3'd0 : gnt_idx + 3'd1;
            we_d   = (gnt_rd != '0);
            rw_d   = gnt_rd;
            busw_d = gnt_data;
        end

        pending_d = pending_q;
        if (we_q) begin
            pending_d[rw_q] = 1'b0;
        end
        if (issue_acc) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            we_q      <= 1'b0;
            rw_q      <= '0;
            busw_q    <= '0;
            pending_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            rw_q      <= rw_d;
            busw_q    <= busw_d;
            pending_q <= pending_d;
        end
    end

    assign req_ready_o = gnt;
    assign we_o        = we_q;
    assign rw_o        = rw_q;
    assign busw_o      = busw_q;
    assign pending_o   = pending_q;
    assign hz_a_o      = pending_q[ra_i];
    assign hz_b_o      = pending_q[rb_i];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Scoreboard bench for regfile_wb_sched with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_rd;
    logic [N*XL-1:0] req_data;
    logic            we;
    logic [4:0]      rw;
    logic [XL-1:0]   busw;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_stall;
    logic [4:0]      ra, rb;
    logic            hz_a, hz_b;
    logic [31:0]     pending;

    always #5 clk = ~clk;

    regfile_wb_sched #(.NREQ(N), .XLEN(XL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_rd_i      (req_rd),
        .req_data_i    (req_data),
        .we_o          (we),
        .rw_o          (rw),
        .busw_o        (busw),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_stall_o (issue_stall),
        .ra_i          (ra),
        .rb_i          (rb),
        .hz_a_o        (hz_a),
        .hz_b_o        (hz_b),
        .pending_o     (pending)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [37:0] exp_q[$];

    // Reference state: register-file port contents and scoreboard as the spec describes them.
    int          m_ptr;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    int          m_gnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] eg;
        logic         es;
        logic [31:0]  np;
        m_gnt = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_gnt < 0 && req_valid[i]) m_gnt = i;
        end
        eg = '0;
        if (m_gnt >= 0) eg[m_gnt] = 1'b1;
        es = issue_valid && (issue_rd != 0) && m_pend[issue_rd] && !(m_we && m_rw == issue_rd);
        chk("req_ready", req_ready, eg);
        chk("issue_stall", issue_stall, es);
        chk("hz_a", hz_a, m_pend[ra]);
        chk("hz_b", hz_b, m_pend[rb]);
        chk("pending", pending, m_pend);
        np = m_pend;
        if (m_we) np[m_rw] = 1'b0;
        if (issue_valid && !es && issue_rd != 0) np[issue_rd] = 1'b1;
        m_pend = np;
        if (m_gnt >= 0) begin
            m_rw   = req_rd[m_gnt*5 +: 5];
            m_we   = (m_rw != 0);
            m_busw = req_data[m_gnt*XL +: XL];
            m_ptr  = (m_gnt + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        exp_q.push_back({m_we, m_rw, m_busw});
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*5-1:0] rd, input logic [N*XL-1:0] d,
                         input logic iv, input logic [4:0] ird, input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        req_valid = v; req_rd = rd; req_data = d;
        issue_valid = iv; issue_rd = ird; ra = a; rb = b;
        @(negedge clk);
        step();
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        drive('0, '0, '0, 1'b0, 5'd0, a, b);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; ra = '0; rb = '0;
        rst_n = 1'b1;
        m_ptr = 0; m_pend = '0; m_we = 1'b0; m_rw = '0; m_busw = '0;
        exp_q.delete();
        exp_q.push_back('0);
        @(negedge clk);
        step();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        release_rst();
    endtask

    // Monitor: registered write-port outputs against the queued expectations.
    initial begin
        logic [37:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (rst_n === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL monitor_underflow: got empty queue expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("writeback", {we, rw, busw}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [N-1:0] rv;
    logic [4:0]   rrd  [N];
    logic [31:0]  rdat [N];
    logic [N*5-1:0]  prd;
    logic [N*XL-1:0] pdat;

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; ra = '0; rb = '0;
        repeat (3) @(posedge clk);
        release_rst();

        // Build pending = 0x0F00 with a live write, then reset asynchronously.
        drive('0, '0, '0, 1'b1, 5'd8,  5'd0, 5'd0);
        drive('0, '0, '0, 1'b1, 5'd9,  5'd0, 5'd0);
        drive('0, '0, '0, 1'b1, 5'd10, 5'd0, 5'd0);
        drive('0, '0, '0, 1'b1, 5'd11, 5'd0, 5'd0);
        drive(3'b001, {10'd0, 5'd3}, {64'd0, 32'hCAFE_0003}, 1'b0, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        chk("pre_reset_pending", pending, 32'h0000_0F00);
        chk("pre_reset_we", we, 1);
        req_valid = 3'b110; issue_valid = 1'b1; issue_rd = 5'd8;
        rst_n = 1'b0;
        #1;
        chk("reset_pending", pending, 0);
        chk("reset_we", we, 0);
        chk("reset_rw", rw, 0);
        chk("reset_busw", busw, 0);
        chk("reset_ready_ptr0", req_ready, 3'b010);
        chk("reset_stall", issue_stall, 0);
        exp_q.delete();
        release_rst();

        // Single request on index 1; pointer then sits at 2.
        drive(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0}, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("ptr_after_single", req_ready, 3'b100);

        // All valid from reset: grants rotate 0,1,2,...
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333_0000 + 32'(c), 32'h2222_0000 + 32'(c), 32'h1111_0000 + 32'(c)},
                  1'b0, 5'd0, 5'd0, 5'd0);
            chk("rr_order", req_ready, 3'b001 << (c % 3));
        end

        // RAW/WAW on r7.
        drive('0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        idle(5'd7, 5'd0);
        chk("raw_hz_a_set", hz_a, 1);
        drive('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        chk("waw_stall", issue_stall, 1);
        drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h7777_7777, 32'd0}, 1'b0, 5'd0, 5'd7, 5'd0);
        idle(5'd7, 5'd0);
        chk("hz_a_during_write", hz_a, 1);
        idle(5'd7, 5'd0);
        chk("hz_a_cleared", hz_a, 0);

        // Same-cycle clear and re-issue on r9.
        drive('0, '0, '0, 1'b1, 5'd9, 5'd0, 5'd0);
        drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h9999_0009, 64'd0}, 1'b0, 5'd0, 5'd0, 5'd0);
        drive('0, '0, '0, 1'b1, 5'd9, 5'd0, 5'd9);
        chk("same_cycle_stall", issue_stall, 0);
        idle(5'd0, 5'd9);
        chk("same_cycle_pending9", pending[9], 1);

        // rd = 0 writeback and issue.
        drive(3'b001, {10'd0, 5'd0}, {64'd0, 32'h0000_1234}, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("rd0_ready", req_ready, 3'b001);
        drive('0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("rd0_we", we, 0);
        chk("rd0_issue_stall", issue_stall, 0);
        idle(5'd0, 5'd0);
        chk("rd0_pending_bit0", pending[0], 0);

        // Randomised traffic with requesters honouring the hold rule.
        rv = '0;
        for (int i = 0; i < N; i++) begin rrd[i] = '0; rdat[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                prd[i*5 +: 5]   = rrd[i];
                pdat[i*XL +: XL] = rdat[i];
            end
            drive(rv, prd, pdat, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            for (int i = 0; i < N; i++) begin
                if (rv[i] && m_gnt == i) rv[i] = 1'b0;
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i]   = 1'b1;
                    rrd[i]  = 5'($urandom_range(0, 15));
                    rdat[i] = $urandom;
                end
            end
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
